// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with a single-outstanding-request memory
// port and a 2-entry {instr, pc} FIFO towards decode.
//
// Ports:
//   clk, reset       sole clock; asynchronous active-high reset
//   imem_req         request outstanding (high whenever the FSM is not idle)
//   imem_addr        word-aligned fetch address, held while imem_req is high
//   imem_ack         memory completes the current request this cycle
//   imem_rdata       instruction word, valid with imem_ack
//   instr_valid      FIFO head holds an instruction
//   instr_ready      decode accepts the head this cycle
//   instr, instr_pc  FIFO head word and its address (zero when empty)
//   opcode           instr[31:26]
//   branch_taken/branch_target, jump/jump_target
//                    redirect requests from execute; jump wins when both set
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [5:0]  opcode,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target
);

  // StReqDiscard: a redirect arrived while a request was in flight; the
  // address must stay stable until the memory acks, and that data is dropped.
  typedef enum logic [1:0] {StIdle, StReq, StReqDiscard} state_e;

  state_e      state_q;
  logic        imem_req_q;
  logic [31:0] next_pc_q;
  logic [31:0] fetch_addr_q;
  logic [1:0]  count_q;
  logic [31:0] head_instr_q, head_pc_q;
  logic [31:0] tail_instr_q, tail_pc_q;

  logic        redirect;
  logic [31:0] redirect_target;
  logic        push;
  logic        pop;
  logic [1:0]  count_next;
  logic        wr_head;

  always_comb begin
    redirect        = jump | branch_taken;
    redirect_target = (jump ? jump_target : branch_target) & 32'hFFFF_FFFC;
    instr_valid     = (count_q != 2'd0);
    pop             = instr_valid & instr_ready;
    // A redirect kills the returning word even when it is acked this cycle.
    push            = (state_q == StReq) & imem_ack & ~redirect;

    count_next = count_q;
    if (redirect) begin
      count_next = 2'd0;
    end else if (push && !pop) begin
      count_next = count_q + 2'd1;
    end else if (pop && !push) begin
      count_next = count_q - 2'd1;
    end

    // Write slot after the (optional) pop has shifted the tail into the head.
    wr_head = pop ? (count_q == 2'd1) : (count_q == 2'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      imem_req_q   <= 1'b0;
      next_pc_q    <= RESET_PC;
      fetch_addr_q <= RESET_PC;
      count_q      <= 2'd0;
      head_instr_q <= 32'h0;
      head_pc_q    <= 32'h0;
      tail_instr_q <= 32'h0;
      tail_pc_q    <= 32'h0;
    end else begin
      count_q <= count_next;

      if (pop) begin
        head_instr_q <= tail_instr_q;
        head_pc_q    <= tail_pc_q;
      end
      if (push) begin
        if (wr_head) begin
          head_instr_q <= imem_rdata;
          head_pc_q    <= fetch_addr_q;
        end else begin
          tail_instr_q <= imem_rdata;
          tail_pc_q    <= fetch_addr_q;
        end
      end

      unique case (state_q)
        StIdle: begin
          if (redirect) begin
            state_q      <= StReq;
            imem_req_q   <= 1'b1;
            fetch_addr_q <= redirect_target;
            next_pc_q    <= redirect_target;
          end else if (count_q < 2'd2) begin
            state_q      <= StReq;
            imem_req_q   <= 1'b1;
            fetch_addr_q <= next_pc_q;
          end
        end

        StReq: begin
          if (imem_ack && !redirect) begin
            next_pc_q <= fetch_addr_q + 32'd4;
            if (count_next < 2'd2) begin
              fetch_addr_q <= fetch_addr_q + 32'd4;
            end else begin
              state_q    <= StIdle;
              imem_req_q <= 1'b0;
            end
          end else if (redirect && !imem_ack) begin
            // Request still in flight: keep the address, remember the target.
            state_q   <= StReqDiscard;
            next_pc_q <= redirect_target;
          end else if (redirect && imem_ack) begin
            fetch_addr_q <= redirect_target;
            next_pc_q    <= redirect_target;
          end
        end

        StReqDiscard: begin
          if (imem_ack) begin
            state_q <= StReq;
            if (redirect) begin
              fetch_addr_q <= redirect_target;
              next_pc_q    <= redirect_target;
            end else begin
              fetch_addr_q <= next_pc_q;
            end
          end else if (redirect) begin
            next_pc_q <= redirect_target;
          end
        end

        default: begin
          state_q    <= StIdle;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    imem_req  = imem_req_q;
    imem_addr = fetch_addr_q;
    instr     = instr_valid ? head_instr_q : 32'h0;
    instr_pc  = instr_valid ? head_pc_q : 32'h0;
    opcode    = instr[31:26];
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [5:0]  opcode;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = 32'h0;

  // Second instance checking the wrap-around reset PC.
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_ack;
  logic [31:0] w_rdata;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic [5:0]  w_opcode;

  int          lat = 0;
  int          mem_cnt;
  logic        ack_force = 1'b0;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  typedef struct {
    logic        jmp;
    logic        br;
    logic [31:0] jtgt;
    logic [31:0] btgt;
    logic [31:0] exp_addr;
  } redir_vec_t;

  redir_vec_t vecs[5];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .opcode        (opcode),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (w_req),
    .imem_addr     (w_addr),
    .imem_ack      (w_ack),
    .imem_rdata    (w_rdata),
    .instr_valid   (w_valid),
    .instr_ready   (instr_ready),
    .instr         (w_instr),
    .instr_pc      (w_pc),
    .opcode        (w_opcode),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target)
  );

  // Memory model: ack after 'lat' wait cycles; data is the inverted address.
  assign imem_ack   = ack_force | (imem_req && (mem_cnt == lat));
  assign imem_rdata = ~imem_addr;
  assign w_ack      = w_req;
  assign w_rdata    = ~w_addr;

  always @(posedge clk or posedge reset) begin
    if (reset) mem_cnt <= 0;
    else if (imem_req && imem_ack) mem_cnt <= 0;
    else if (imem_req) mem_cnt <= mem_cnt + 1;
    else mem_cnt <= 0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted instruction is compared against the queue head.
  always @(negedge clk) begin
    if (!reset && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_delivery: got pc %h expected none", instr_pc);
      end else begin
        mon_exp = exp_q.pop_front();
        check("deliver_pc", instr_pc, mon_exp);
        check("deliver_instr", instr, ~mon_exp);
        check("deliver_opcode", {26'h0, opcode}, (~mon_exp) >> 26);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    vecs[0] = '{1'b1, 1'b1, 32'h0000_0200, 32'h0000_0300, 32'h0000_0200};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_0300, 32'h0000_0300};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0403, 32'h0000_0000, 32'h0000_0400};
    vecs[3] = '{1'b0, 1'b1, 32'h0000_0000, 32'h1001_0006, 32'h1001_0004};
    vecs[4] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0008, 32'hFFFF_FFFC};

    // Reset values
    step();
    step();
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc", instr_pc, 32'h0);
    check("rst_opcode", opcode, 0);
    check("rst_wrap_addr", w_addr, 32'hFFFF_FFFC);

    // Zero-wait streaming with decode always ready
    exp_q.delete();
    for (int i = 0; i < 18; i++) exp_q.push_back(32'(i * 4));
    instr_ready = 1'b1;
    reset = 1'b0;
    check("req_before_first_edge", imem_req, 0);
    for (int k = 1; k <= 20; k++) begin
      step();
      check("stream_req", imem_req, 1);
      check("stream_addr", imem_addr, 32'((k - 1) * 4));
      if (k >= 2) check("stream_valid", instr_valid, 1);
      if (k == 2) check("first_instr_pc", instr_pc, 32'h0);
      if (k == 1) check("wrap_first_addr", w_addr, 32'hFFFF_FFFC);
      if (k == 2) begin
        check("wrap_second_addr", w_addr, 32'h0);
        check("wrap_first_pc", w_pc, 32'hFFFF_FFFC);
      end
    end
    instr_ready = 1'b0;
    step();
    check("stream_drained", exp_q.size(), 0);

    // Backpressure: FIFO fills, request drops, resumes in order
    reset = 1'b1;
    step();
    exp_q.delete();
    reset = 1'b0;
    step();
    step();
    step();
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_req_low", imem_req, 0);
    end
    check("bp_valid", instr_valid, 1);
    check("bp_head_pc", instr_pc, 32'h0);
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(i * 4));
    instr_ready = 1'b1;
    step();
    step();
    check("bp_resume_req", imem_req, 1);
    check("bp_resume_addr", imem_addr, 32'h8);
    repeat (4) step();
    instr_ready = 1'b0;
    step();
    check("bp_drained", exp_q.size(), 0);

    // Branch during the second wait cycle of a 3-wait-cycle fetch
    reset = 1'b1;
    lat = 3;
    step();
    exp_q.delete();
    reset = 1'b0;
    step();
    check("lat_req", imem_req, 1);
    check("lat_addr", imem_addr, 32'h0);
    step();
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0100;
    step();
    branch_taken  = 1'b0;
    check("discard_req", imem_req, 1);
    check("discard_hold_addr", imem_addr, 32'h0);
    step();
    step();
    check("discard_new_addr", imem_addr, 32'h0000_0100);
    check("discard_req2", imem_req, 1);
    check("discard_empty", instr_valid, 0);
    exp_q.push_back(32'h0000_0100);
    n = 0;
    while (!instr_valid && n < 20) begin
      step();
      n++;
    end
    check("discard_wait_valid", instr_valid, 1);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    step();
    check("discard_drained", exp_q.size(), 0);

    // Redirect in the same cycle as an ack
    reset = 1'b1;
    lat = 0;
    step();
    exp_q.delete();
    reset = 1'b0;
    step();
    jump        = 1'b1;
    jump_target = 32'h0000_0500;
    step();
    jump = 1'b0;
    check("ack_redir_addr", imem_addr, 32'h0000_0500);
    check("ack_redir_req", imem_req, 1);
    check("ack_redir_empty", instr_valid, 0);
    step();
    check("ack_redir_valid", instr_valid, 1);
    check("ack_redir_pc", instr_pc, 32'h0000_0500);
    step();

    // Redirect table, applied from idle with a full FIFO
    foreach (vecs[i]) begin
      repeat (3) step();
      check("tbl_idle", imem_req, 0);
      jump          = vecs[i].jmp;
      branch_taken  = vecs[i].br;
      jump_target   = vecs[i].jtgt;
      branch_target = vecs[i].btgt;
      step();
      jump         = 1'b0;
      branch_taken = 1'b0;
      check("tbl_addr", imem_addr, vecs[i].exp_addr);
      check("tbl_req", imem_req, 1);
      check("tbl_flushed", instr_valid, 0);
      step();
      step();
      exp_q.push_back(vecs[i].exp_addr);
      exp_q.push_back(vecs[i].exp_addr + 32'd4);
      instr_ready = 1'b1;
      step();
      step();
      instr_ready = 1'b0;
      step();
      check("tbl_drained", exp_q.size(), 0);
    end

    // Reset in the middle of a request with a stray ack
    reset = 1'b1;
    lat = 3;
    step();
    exp_q.delete();
    reset = 1'b0;
    step();
    check("midrst_req_before", imem_req, 1);
    step();
    reset = 1'b1;
    #1;
    check("midrst_req", imem_req, 0);
    check("midrst_addr", imem_addr, 32'h0);
    ack_force = 1'b1;
    step();
    step();
    check("midrst_req_hold", imem_req, 0);
    check("midrst_valid", instr_valid, 0);
    check("midrst_instr", instr, 32'h0);
    check("midrst_pc", instr_pc, 32'h0);
    check("midrst_opcode", opcode, 0);
    reset = 1'b0;
    check("midrst_idle_ack", imem_req, 0);
    step();
    ack_force = 1'b0;
    check("midrst_restart_req", imem_req, 1);
    check("midrst_restart_addr", imem_addr, 32'h0);
    check("midrst_no_push", instr_valid, 0);
    step();
    check("midrst_no_push2", instr_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
